// File: rtl/csa_pkg.sv
// Shared types and defaults for the serial carry-save accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } csa_state_e;

  localparam int CSA_WIDTH     = 16;
  localparam int CSA_NUM_OPS   = 9;
  localparam int CSA_OUT_WIDTH = 20;

  function automatic int csa_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_row_3to2.sv
// One OUT_WIDTH-bit 3:2 compressor row; carry is returned already shifted left by one.
module csa_row_3to2 #(
  parameter int W = 20
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] maj;

  assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/carry_save_accumulator.sv
// Serial carry-save accumulator: one 3:2 compression per operand, then carry resolution.
// Optional early-termination input flush is enabled by defining CSA_ACC_FLUSH_EN.
//
// state   | meaning
// ACCUM   | accepting operands, total held as sum/carry pair
// RESOLVE | folding carry into sum until carry is zero
// DONE    | result presented on sum, waiting for out_ready
module carry_save_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH     = CSA_WIDTH,
  parameter int NUM_OPS   = CSA_NUM_OPS,
  parameter int OUT_WIDTH = CSA_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] sum,
`ifdef CSA_ACC_FLUSH_EN
  input  logic                 flush,
`endif
  output logic                 busy
);

  localparam int CNT_W = csa_clog2(NUM_OPS);

  csa_state_e           state_q, state_d;
  logic [OUT_WIDTH-1:0] s_q, s_d;
  logic [OUT_WIDTH-1:0] c_q, c_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] sum_q, sum_d;
  logic                 ov_q, ov_d;

  logic [OUT_WIDTH-1:0] x_ext;
  logic [OUT_WIDTH-1:0] row_c;
  logic [OUT_WIDTH-1:0] row_sum;
  logic [OUT_WIDTH-1:0] row_carry;
  logic                 accept;
  logic                 last_op;

  assign x_ext   = {{(OUT_WIDTH-WIDTH){1'b0}}, in_data};
  assign accept  = in_valid && (state_q == ACCUM);
  assign last_op = (cnt_q == CNT_W'(NUM_OPS - 1));

  // RESOLVE reuses the same row with the operand input forced to zero
  assign row_c = (state_q == ACCUM) ? x_ext : '0;

  csa_row_3to2 #(.W(OUT_WIDTH)) u_row (
    .a_i     (s_q),
    .b_i     (c_q),
    .c_i     (row_c),
    .sum_o   (row_sum),
    .carry_o (row_carry)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ov_d    = ov_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          s_d   = row_sum;
          c_d   = row_carry;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_op) begin
            cnt_d   = '0;
            state_d = RESOLVE;
          end
        end
`ifdef CSA_ACC_FLUSH_EN
        if (flush) begin
          cnt_d   = '0;
          state_d = RESOLVE;
        end
`endif
      end
      RESOLVE: begin
        if (c_q == '0) begin
          sum_d   = s_q;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          s_d = row_sum;
          c_d = row_carry;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          s_d     = '0;
          c_d     = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != ACCUM);
  assign out_valid = ov_q;
  assign sum       = sum_q;

endmodule
